// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: forwarding selects, load-use and branch
// handling, multi-cycle mul/div sequencing and a saturating fetch-stall counter.
module hazard_ctrl #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             memread_e,
    input  logic             mul_start_e,
    input  logic             branch_sig,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_w,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam bit         MulMulti = (MUL_LATENCY > 1);
    localparam logic [3:0] CntInit  = 4'(MUL_LATENCY >= 2 ? MUL_LATENCY - 2 : 0);

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic lu, mul_go, mul_stall, flush_e_raw;

    always_comb begin
        fwd_a_e = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs1_e) begin
            fwd_a_e = 2'b10;
        end else if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_e) begin
            fwd_a_e = 2'b01;
        end

        fwd_b_e = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs2_e) begin
            fwd_b_e = 2'b10;
        end else if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_e) begin
            fwd_b_e = 2'b01;
        end
    end

    always_comb begin
        lu = memread_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
        // A stray mul_start_e alongside a branch is ignored: the branch wins.
        mul_go      = (state_q == StIdle) && mul_start_e && !branch_sig && MulMulti;
        mul_stall   = mul_go || (state_q == StBusy && cnt_q != 4'd0);
        flush_e_raw = branch_sig || lu;

        // Outputs are forced low while reset is held, independent of inputs.
        stallF   = reset && (lu || mul_stall) && !branch_sig;
        stallD   = reset && (lu || mul_stall) && !branch_sig;
        stallE   = reset && mul_stall && !flush_e_raw;
        flushD   = reset && branch_sig;
        flushE   = reset && flush_e_raw;
        flushM   = reset && mul_stall;
        mul_busy = reset && (state_q == StBusy);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mul_go) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end
            end
            default: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stallF && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (latency 4, latency 1, 4-bit counter)
// share one set of inputs; each check compares against hand-computed values.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       memread_e, mul_start_e, branch_sig, regwrite_m, regwrite_w;

    // Instance A: MUL_LATENCY=4, CNT_W=32
    logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a, mb_a;
    logic [1:0]  fa_a, fb_a;
    logic [31:0] cnt_a;
    // Instance B: MUL_LATENCY=1, CNT_W=32
    logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b, mb_b;
    logic [1:0]  fa_b, fb_b;
    logic [31:0] cnt_b;
    // Instance C: MUL_LATENCY=4, CNT_W=4
    logic        sf_c, sd_c, se_c, fd_c, fe_c, fm_c, mb_c;
    logic [1:0]  fa_c, fb_c;
    logic [3:0]  cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .memread_e(memread_e), .mul_start_e(mul_start_e), .branch_sig(branch_sig),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stallF(sf_a), .stallD(sd_a), .stallE(se_a), .flushD(fd_a), .flushE(fe_a),
        .flushM(fm_a), .fwd_a_e(fa_a), .fwd_b_e(fb_a), .mul_busy(mb_a), .stall_count(cnt_a)
    );

    hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(32)) u_dut_b (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .memread_e(memread_e), .mul_start_e(mul_start_e), .branch_sig(branch_sig),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stallF(sf_b), .stallD(sd_b), .stallE(se_b), .flushD(fd_b), .flushE(fe_b),
        .flushM(fm_b), .fwd_a_e(fa_b), .fwd_b_e(fb_b), .mul_busy(mb_b), .stall_count(cnt_b)
    );

    hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .memread_e(memread_e), .mul_start_e(mul_start_e), .branch_sig(branch_sig),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stallF(sf_c), .stallD(sd_c), .stallE(se_c), .flushD(fd_c), .flushE(fe_c),
        .flushM(fm_c), .fwd_a_e(fa_c), .fwd_b_e(fb_c), .mul_busy(mb_c), .stall_count(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0; memread_e = 1'b0; mul_start_e = 1'b0;
        branch_sig = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    endtask

    // Packs {stallF, stallD, stallE, flushM} of instance A.
    function automatic logic [3:0] mul_bits_a();
        return {sf_a, sd_a, se_a, fm_a};
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b0;
        memread_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; mul_start_e = 1'b1;
        #3;
        check("rst_stallF", sf_a, 0);
        check("rst_flushE", fe_a, 0);
        check("rst_stall_outs", {sd_a, se_a, fd_a, fm_a, mb_a}, 0);
        @(posedge clk); #1;
        check("rst_count", cnt_a, 0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Forwarding
        rs1_e = 5'd5; rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
        #1 check("fwd_a_m", fa_a, 2'b10);
        regwrite_m = 1'b0;
        #1 check("fwd_a_w", fa_a, 2'b01);
        rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; regwrite_m = 1'b1;
        #1 check("fwd_a_x0", fa_a, 2'b00);
        rs2_e = 5'd9; rd_m = 5'd9; rd_w = 5'd9; rs1_e = 5'd4;
        #1 check("fwd_b_m", fb_a, 2'b10);
        check("fwd_a_none", fa_a, 2'b00);
        rd_m = 5'd8;
        #1 check("fwd_b_w", fb_a, 2'b01);
        clear_inputs();

        // Load-use, one cycle
        @(negedge clk);
        memread_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1 check("lu_stallF", sf_a, 1);
        check("lu_stallD", sd_a, 1);
        check("lu_flushE", fe_a, 1);
        check("lu_stallE", se_a, 0);
        check("lu_flushD", fd_a, 0);
        @(negedge clk);
        clear_inputs();
        #1 check("lu_count", cnt_a, 1);
        check("lu_released", sf_a, 0);

        // Multi-cycle op, held 4 cycles
        @(negedge clk);
        mul_start_e = 1'b1; rs1_d = 5'd2;
        #1 check("mul_c0_stalls", mul_bits_a(), 4'b1111);
        check("mul_c0_busy", mb_a, 0);
        check("mul1_c0_stallF", sf_b, 0);
        check("mul1_c0_stallE", se_b, 0);
        @(negedge clk); #1;
        check("mul_c1_stalls", mul_bits_a(), 4'b1111);
        check("mul_c1_busy", mb_a, 1);
        @(negedge clk); #1;
        check("mul_c2_stalls", mul_bits_a(), 4'b1111);
        check("mul_c2_busy", mb_a, 1);
        @(negedge clk); #1;
        check("mul_c3_stalls", mul_bits_a(), 4'b0000);
        @(negedge clk);
        mul_start_e = 1'b0;
        #1 check("mul_c4_busy", mb_a, 0);
        check("mul_count", cnt_a, 4);
        check("mul1_count", cnt_b, 1);
        check("mul1_busy", mb_b, 0);

        // Branch overrides load-use
        memread_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; branch_sig = 1'b1;
        #1 check("br_flushD", fd_a, 1);
        check("br_flushE", fe_a, 1);
        check("br_stallF", sf_a, 0);
        check("br_stallD", sd_a, 0);
        @(negedge clk);
        check("br_count", cnt_a, 4);
        // Branch together with mul_start_e: branch wins, FSM stays idle
        memread_e = 1'b0; mul_start_e = 1'b1;
        #1 check("br_mul_stalls", mul_bits_a(), 4'b0000);
        @(negedge clk);
        branch_sig = 1'b0; mul_start_e = 1'b0;
        #1 check("br_mul_busy", mb_a, 0);
        clear_inputs();

        // Reset during BUSY with cnt=1
        @(negedge clk);
        mul_start_e = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre_rst_busy", mb_a, 1);
        reset = 1'b0;
        #1 check("rst_mid_stalls", mul_bits_a(), 4'b0000);
        check("rst_mid_busy", mb_a, 0);
        check("rst_mid_count", cnt_a, 0);
        @(negedge clk);
        reset = 1'b1; mul_start_e = 1'b0;
        #1 check("post_rst_stallF", sf_a, 0);
        @(negedge clk); #1;
        check("post_rst_busy", mb_a, 0);
        mul_start_e = 1'b1;
        #1 check("new_c0_stalls", mul_bits_a(), 4'b1111);
        @(negedge clk); #1 check("new_c1_stalls", mul_bits_a(), 4'b1111);
        @(negedge clk); #1 check("new_c2_stalls", mul_bits_a(), 4'b1111);
        @(negedge clk); #1 check("new_c3_stalls", mul_bits_a(), 4'b0000);
        @(negedge clk);
        mul_start_e = 1'b0;
        #1 check("new_count", cnt_a, 3);
        check("new_count_c", cnt_c, 3);

        // Saturation of the 4-bit counter under continuous load-use
        memread_e = 1'b1; rd_e = 5'd11; rs1_d = 5'd11;
        repeat (12) @(posedge clk);
        #1 check("sat_reach", cnt_c, 15);
        repeat (8) @(posedge clk);
        #1 check("sat_hold", cnt_c, 15);
        check("sat_wide", cnt_a, 23);
        clear_inputs();
        @(negedge clk);
        check("sat_stable", cnt_c, 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
